decode_sequencer: RTL and testbench

- Parametrised, buffered successor to the combinational instruction decoder.
- Accepts 16-bit instructions into a QDEPTH-entry FIFO and decodes the head into registered fields.
- Walks a per-instruction FSM that issues one register-file access step at a time (nsel one-hot, readnum/writenum), using a valid/ready handshake toward the datapath controller.
- Sits between instruction fetch and the register file/datapath.

---
 rtl/decode_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_decode_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// Buffered instruction decoder: a QDEPTH-entry FIFO feeds a per-instruction FSM that
// issues register-file steps over a valid/ready handshake. Define DECODE_ERR_CNT_EN to add err_cnt.
module decode_sequencer #(
  parameter int WORD_W = 16,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic              step_valid,
  input  logic              step_ready,
  output logic [2:0]        nsel,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              step_write,
  output logic              step_last,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [WORD_W-1:0] sximm5,
  output logic [WORD_W-1:0] sximm8,
  output logic              busy,
  output logic              illegal
`ifdef DECODE_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int PTR_W = $clog2(QDEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_RN = 3'd1,
    S_RD_RM = 3'd2,
    S_WR_RD = 3'd3,
    S_WR_RN = 3'd4
  } state_t;

  // Entry state for an instruction class; S_IDLE marks an undecodable word.
  function automatic state_t f_first_state(input logic [15:0] ins);
    state_t s;
    case ({ins[15:13], ins[12:11]})
      5'b110_10:            s = S_WR_RN;
      5'b110_00:            s = S_RD_RM;
      5'b101_00, 5'b101_10: s = S_RD_RN;
      5'b101_01:            s = S_RD_RN;
      5'b101_11:            s = S_RD_RM;
      default:              s = S_IDLE;
    endcase
    return s;
  endfunction

  function automatic logic f_is_cmp(input logic [15:0] ins);
    return ins[15:11] == 5'b101_01;
  endfunction

  function automatic logic [7:0] f_sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [15:0]      r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic             r_full, r_empty;
  logic [15:0]      r_instr;
  logic             r_illegal;
  state_t           r_state, w_next_state;

  logic [PTR_W-1:0] w_wptr_nxt, w_rptr_nxt;
  logic [15:0]      w_head;
  logic             w_push, w_pop, w_accept;

  assign w_wptr_nxt = r_wptr + PTR_W'(1);
  assign w_rptr_nxt = r_rptr + PTR_W'(1);
  assign w_head     = r_mem[r_rptr];
  assign w_push     = in_valid && !r_full;
  assign w_accept   = step_valid && step_ready;
  // Pop either from idle or on the accepted last step, so sequences run back-to-back.
  assign w_pop      = !r_empty && ((r_state == S_IDLE) || (w_accept && step_last));

  assign in_ready = !r_full;
  assign busy     = (r_state != S_IDLE);
  assign illegal  = r_illegal;
  assign writenum = readnum;

  assign opcode = r_instr[15:13];
  assign op     = r_instr[12:11];
  assign ALUop  = r_instr[12:11];
  assign shift  = r_instr[4:3];
  assign sximm5 = {{(WORD_W-5){r_instr[4]}}, r_instr[4:0]};
  assign sximm8 = {{(WORD_W-8){r_instr[7]}}, r_instr[7:0]};

  always_comb begin
    step_valid = 1'b0;
    nsel       = 3'b000;
    readnum    = 3'd0;
    step_write = 1'b0;
    step_last  = 1'b0;
    case (r_state)
      S_RD_RN: begin
        step_valid = 1'b1;
        nsel       = 3'b001;
        readnum    = r_instr[10:8];
      end
      S_RD_RM: begin
        step_valid = 1'b1;
        nsel       = 3'b100;
        readnum    = r_instr[2:0];
        step_last  = f_is_cmp(r_instr);
      end
      S_WR_RD: begin
        step_valid = 1'b1;
        nsel       = 3'b010;
        readnum    = r_instr[7:5];
        step_write = 1'b1;
        step_last  = 1'b1;
      end
      S_WR_RN: begin
        step_valid = 1'b1;
        nsel       = 3'b001;
        readnum    = r_instr[10:8];
        step_write = 1'b1;
        step_last  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    if (w_pop) begin
      w_next_state = f_first_state(w_head);
    end else if (w_accept) begin
      if (step_last) begin
        w_next_state = S_IDLE;
      end else begin
        case (r_state)
          S_RD_RN: w_next_state = S_RD_RM;
          S_RD_RM: w_next_state = S_WR_RD;
          default: w_next_state = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_instr   <= 16'h0000;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_illegal <= w_pop && (f_first_state(w_head) == S_IDLE);
      if (w_pop) begin
        r_instr <= w_head;
      end
    end
  end

  // FIFO storage holds data only; occupancy lives in the pointers and flags below.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= instr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      if (w_push && !w_pop) begin
        r_empty <= 1'b0;
        r_full  <= (w_wptr_nxt == r_rptr);
      end else if (w_pop && !w_push) begin
        r_full  <= 1'b0;
        r_empty <= (w_rptr_nxt == r_wptr);
      end
    end
  end

`ifdef DECODE_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_cnt <= 8'd0;
    end else if (r_illegal) begin
      r_err_cnt <= f_sat_inc(r_err_cnt);
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: expected steps are queued on each accepted push
// and popped as the DUT hands steps (or illegal pulses) to the consumer.
module tb_decode_sequencer;
  localparam int WORD_W = 16;
  localparam int QDEPTH = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instr;
  logic              step_valid;
  logic              step_ready;
  logic [2:0]        nsel, readnum, writenum;
  logic              step_write, step_last;
  logic [2:0]        opcode;
  logic [1:0]        op, ALUop, shift;
  logic [WORD_W-1:0] sximm5, sximm8;
  logic              busy, illegal;
`ifdef DECODE_ERR_CNT_EN
  logic [7:0]        err_cnt;
`endif

  always #5 clk = ~clk;

  decode_sequencer #(.WORD_W(WORD_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .step_valid(step_valid), .step_ready(step_ready), .nsel(nsel), .readnum(readnum),
    .writenum(writenum), .step_write(step_write), .step_last(step_last), .opcode(opcode),
    .op(op), .ALUop(ALUop), .shift(shift), .sximm5(sximm5), .sximm8(sximm8),
    .busy(busy), .illegal(illegal)
`ifdef DECODE_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  typedef struct packed {
    logic        ill;
    logic [2:0]  nsel;
    logic [2:0]  num;
    logic        wr;
    logic        last;
    logic [15:0] ins;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] sx5(input logic [15:0] v);
    logic [WORD_W-1:0] r;
    r = {WORD_W{v[4]}};
    r[4:0] = v[4:0];
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] sx8(input logic [15:0] v);
    logic [WORD_W-1:0] r;
    r = {WORD_W{v[7]}};
    r[7:0] = v[7:0];
    return r;
  endfunction

  function automatic exp_t mk(input logic ill, input logic [2:0] ns, input logic [2:0] num,
                              input logic wr, input logic last, input logic [15:0] ins);
    exp_t e;
    e.ill = ill; e.nsel = ns; e.num = num; e.wr = wr; e.last = last; e.ins = ins;
    return e;
  endfunction

  // Reference step list per instruction class: Rn->001, Rd->010, Rm->100.
  task automatic model_push(input logic [15:0] v);
    logic [2:0] rn, rd, rm;
    rn = v[10:8]; rd = v[7:5]; rm = v[2:0];
    case ({v[15:13], v[12:11]})
      5'b11010: sb.push_back(mk(0, 3'b001, rn, 1, 1, v));
      5'b11000, 5'b10111: begin
        sb.push_back(mk(0, 3'b100, rm, 0, 0, v));
        sb.push_back(mk(0, 3'b010, rd, 1, 1, v));
      end
      5'b10100, 5'b10110: begin
        sb.push_back(mk(0, 3'b001, rn, 0, 0, v));
        sb.push_back(mk(0, 3'b100, rm, 0, 0, v));
        sb.push_back(mk(0, 3'b010, rd, 1, 1, v));
      end
      5'b10101: begin
        sb.push_back(mk(0, 3'b001, rn, 0, 0, v));
        sb.push_back(mk(0, 3'b100, rm, 0, 1, v));
      end
      default: sb.push_back(mk(1, 3'b000, 3'd0, 0, 0, v));
    endcase
  endtask

  task automatic push_instr(input logic [15:0] v);
    logic done;
    done = 1'b0;
    in_valid = 1'b1;
    instr = v;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model_push(v);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    check("push_accept", done, 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] prev_vec, cur_vec;
  logic        prev_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      cur_vec = {12'd0, nsel, readnum, writenum, step_write, step_last, opcode, op, ALUop,
                 shift, sximm5, sximm8};
      if (prev_stall) check("hold", cur_vec, prev_vec);
      if (illegal) begin
        check("ill_nostep", step_valid, 1'b0);
        if (sb.size() == 0) check("sb_unexp_ill", illegal, 1'b0);
        else begin
          e = sb.pop_front();
          check("ill_kind", e.ill, 1'b1);
        end
      end
      if (step_valid && step_ready) begin
        if (sb.size() == 0) check("sb_unexp_step", step_valid, 1'b0);
        else begin
          e = sb.pop_front();
          check("step_kind", e.ill, 1'b0);
          check("step", {nsel, readnum, writenum, step_write, step_last},
                {e.nsel, e.num, e.num, e.wr, e.last});
          check("fields", {opcode, op, ALUop, shift, sximm5, sximm8},
                {e.ins[15:13], e.ins[12:11], e.ins[12:11], e.ins[4:3], sx5(e.ins), sx8(e.ins)});
        end
      end
      prev_stall = step_valid && !step_ready;
      prev_vec   = cur_vec;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    resetn = 1'b0; in_valid = 1'b0; instr = 16'h0000; step_ready = 1'b0;
    #12;
    check("rst_state", {in_ready, step_valid, nsel, busy, illegal, opcode, sximm8},
          {1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, {WORD_W{1'b0}}});
`ifdef DECODE_ERR_CNT_EN
    check("rst_errcnt", err_cnt, 8'd0);
`endif
    align();
    resetn = 1'b1;

    // ADD with pop latency
    align();
    step_ready = 1'b1;
    push_instr(16'hA269);
    check("lat_k", step_valid, 1'b0);
    align();
    check("lat_k1", {step_valid, nsel, readnum}, {1'b1, 3'b001, 3'd2});
    wait_drain();

    // MOV immediate, then idle with fields held
    align();
    push_instr(16'hD180);
    wait_drain();
    align();
    check("mov_idle", {step_valid, nsel, busy, opcode, sximm8},
          {1'b0, 3'b000, 1'b0, 3'b110, 16'hFF80});

    // CMP then MVN back-to-back
    align();
    push_instr(16'hAA69);
    push_instr(16'hB8A3);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (step_valid && step_last && nsel == 3'b100) seen = 1'b1;
    end
    check("cmp_last_seen", seen, 1'b1);
    @(negedge clk);
    check("no_bubble", {step_valid, nsel, readnum, step_write}, {1'b1, 3'b100, 3'd3, 1'b0});
    wait_drain();

    // Backpressure on ADD's RD_RM step
    align();
    push_instr(16'hA269);
    align();
    align();
    step_ready = 1'b0;
    check("bp_enter", {nsel, readnum}, {3'b100, 3'd1});
    for (int i = 0; i < 5; i++) begin
      align();
      check("bp_held", {step_valid, nsel, readnum}, {1'b1, 3'b100, 3'd1});
    end
    step_ready = 1'b1;
    align();
    check("bp_adv", {nsel, writenum, step_write}, {3'b010, 3'd3, 1'b1});
    wait_drain();

    // FIFO full while the consumer stalls
    align();
    step_ready = 1'b0;
    push_instr(16'hA269);
    push_instr(16'hD180);
    push_instr(16'hAA69);
    check("full_rdy", in_ready, 1'b0);
    fork
      push_instr(16'hB8A3);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("full_hold", in_ready, 1'b0);
        end
        align();
        step_ready = 1'b1;
      end
    join
    wait_drain();

    // Illegal instruction
    align();
    push_instr(16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (illegal) seen = 1'b1;
    end
    check("ill_seen", seen, 1'b1);
    check("ill_sv", step_valid, 1'b0);
    @(negedge clk);
    check("ill_pulse", illegal, 1'b0);
`ifdef DECODE_ERR_CNT_EN
    check("errcnt", err_cnt, 8'd1);
`endif
    wait_drain();

    // Asynchronous reset in the middle of an ADD
    align();
    push_instr(16'hA269);
    align();
    align();
    #2;
    resetn = 1'b0;
    sb.delete();
    #1;
    check("rst_mid", {step_valid, in_ready, busy, nsel}, {1'b0, 1'b1, 1'b0, 3'b000});
    align();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst", {step_valid, in_ready}, {1'b0, 1'b1});
    end
`ifdef DECODE_ERR_CNT_EN
    check("post_rst_errcnt", err_cnt, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
